data_bus_router: RTL

//   Parametrised data-side interconnect between the CPU load/store port and NUM_SLV slaves
//   (data memory, peripheral control, future devices). It generalises the fixed two-target
//   RAM/peripheral split to N address-decoded regions.

---
 rtl/data_bus_router.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/data_bus_router.sv
// Data-side interconnect: decodes CPU load/store accesses onto NUM_SLV slave regions, with
// ready handshake, wait-state timeout error and registered interrupt aggregation.
module data_bus_router #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned SEL_LSB = 28,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned IDX_W  = $clog2(NUM_SLV)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req_i,
    input  logic                      cpu_we_i,
    input  logic [ADDR_W-1:0]         cpu_addr_i,
    input  logic [DATA_W-1:0]         cpu_wdata_i,
    output logic [DATA_W-1:0]         cpu_rdata_o,
    output logic                      cpu_ready_o,
    output logic                      cpu_err_o,
    output logic [NUM_SLV-1:0]        slv_cre_o,
    output logic [NUM_SLV-1:0]        slv_cwe_o,
    output logic [ADDR_W-1:0]         slv_addr_o,
    output logic [DATA_W-1:0]         slv_wdata_o,
    input  logic [NUM_SLV*DATA_W-1:0] slv_rdata_i,
    input  logic [NUM_SLV-1:0]        slv_ready_i,
    input  logic [NUM_SLV-1:0]        slv_intreq_i,
    output logic                      intreq_o,
    output logic [IDX_W-1:0]          int_id_o
);

    localparam logic [SEL_W:0] NumSlvSel = (SEL_W + 1)'(NUM_SLV);
    localparam logic [7:0]     TimeoutM1 = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NUM_SLV-1:0]  cre_q, cre_d;
    logic [NUM_SLV-1:0]  cwe_q, cwe_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                intreq_q, intreq_d;
    logic [IDX_W-1:0]    int_id_q, int_id_d;

    logic [SEL_W-1:0]    sel_in;
    logic                dec_err;
    logic [NUM_SLV-1:0]  sel_onehot;
    logic [DATA_W-1:0]   rdata_sel;

    assign sel_in     = cpu_addr_i[SEL_LSB +: SEL_W];
    assign dec_err    = ({1'b0, sel_in} >= NumSlvSel);
    assign sel_onehot = NUM_SLV'(1) << sel_in[IDX_W-1:0];
    assign rdata_sel  = slv_rdata_i[sel_q * DATA_W +: DATA_W];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cre_d   = '0;
        cwe_d   = '0;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req_i) begin
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_wdata_i;
                    we_d    = cpu_we_i;
                    cnt_d   = '0;
                    if (dec_err) begin
                        state_d = StResp;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StAccess;
                        sel_d   = sel_in[IDX_W-1:0];
                        if (cpu_we_i) begin
                            cwe_d = sel_onehot;
                        end else begin
                            cre_d = sel_onehot;
                        end
                    end
                end
            end
            StAccess: begin
                // Only the strobed slave's ready is honoured.
                if (slv_ready_i[sel_q]) begin
                    state_d = StResp;
                    ready_d = 1'b1;
                    rdata_d = we_q ? '0 : rdata_sel;
                end else if (cnt_q == TimeoutM1) begin
                    state_d = StResp;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    cre_d = cre_q;
                    cwe_d = cwe_q;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        intreq_d = |slv_intreq_i;
        int_id_d = '0;
        for (int k = NUM_SLV - 1; k >= 0; k--) begin
            if (slv_intreq_i[k]) begin
                int_id_d = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            cnt_q    <= '0;
            cre_q    <= '0;
            cwe_q    <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            intreq_q <= 1'b0;
            int_id_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            cre_q    <= cre_d;
            cwe_q    <= cwe_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            intreq_q <= intreq_d;
            int_id_q <= int_id_d;
        end
    end

    assign cpu_rdata_o = rdata_q;
    assign cpu_ready_o = ready_q;
    assign cpu_err_o   = err_q;
    assign slv_cre_o   = cre_q;
    assign slv_cwe_o   = cwe_q;
    assign slv_addr_o  = addr_q;
    assign slv_wdata_o = wdata_q;
    assign intreq_o    = intreq_q;
    assign int_id_o    = int_id_q;

endmodule
